// File: rtl/demux8_pkg.sv
`default_nettype none
// ============================================================================
// Module     : demux8_pkg
// Description: Shared types and constants for the 1-to-8 stream demultiplexer.
//              Holds the per-lane state encoding and the lane/select/statistic
//              widths used by demux8_lane and demux8_stream.
// Revision   : 1.0 - initial release
// ============================================================================
package demux8_pkg;

  localparam int NUM_LANES = 8;
  localparam int SEL_W     = 3;
  localparam int STAT_W    = 16;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_t;

endpackage : demux8_pkg
`default_nettype wire

// File: rtl/demux8_lane.sv
`default_nettype none
// ============================================================================
// Module     : demux8_lane
// Description: One destination lane of the demultiplexer. It is a 1-entry
//              output register with an EMPTY/FULL state machine.
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset, empties the lane, clears data
//   accept_i  - a word is being written into this lane this cycle
//   drain_i   - the consumer takes the held word this cycle
//   data_i    - word to load on accept
//   valid_o   - lane holds a word (registered)
//   data_o    - held word (registered)
//   empty_o   - lane is EMPTY (feeds the top-level ready mux)
// Revision   : 1.0 - initial release
// ============================================================================
module demux8_lane
  import demux8_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept_i,
  input  logic             drain_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o
);

  lane_state_t      state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      EMPTY: begin
        if (accept_i) state_d = FULL;
      end
      FULL: begin
        // A same-cycle accept refills the slot the drain frees up.
        if (!accept_i && drain_i) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    // The register is written only on a qualified accept, so the held word
    // stays stable (and survives a drain) until the next write.
    if (accept_i) data_d = data_i;
  end

  assign valid_o = (state_q == FULL);
  assign empty_o = (state_q == EMPTY);
  assign data_o  = data_q;

endmodule : demux8_lane
`default_nettype wire

// File: rtl/demux8_stream.sv
`default_nettype none
// ============================================================================
// Module     : demux8_stream
// Description: 1-to-8 registered demultiplexer with valid/ready handshake.
//              A source word is steered by in_sel into one of eight 1-entry
//              lane registers, each drained independently by its consumer.
//   clk, rst   - clock and synchronous active-high reset
//   in_valid   - producer has a word
//   in_ready   - word is accepted this cycle (depends on in_sel/out_ready,
//                never on in_valid)
//   in_sel     - destination lane 0..7
//   in_data    - word
//   out_valid  - bit i: lane i holds a word
//   out_ready  - bit i: consumer i takes lane i word
//   out_data   - lane i word at [i*WIDTH +: WIDTH]
//   stat_count - (only with DEMUX8_STATS_EN) per-lane saturating 16-bit
//                accept counters, lane i at [i*16 +: 16]
// Optional   : macro DEMUX8_STATS_EN adds stat_count and the counters.
// Revision   : 1.0 - initial release
// ============================================================================
module demux8_stream
  import demux8_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SEL_W-1:0]           in_sel,
  input  logic [WIDTH-1:0]           in_data,
  output logic [NUM_LANES-1:0]       out_valid,
  input  logic [NUM_LANES-1:0]       out_ready,
  output logic [NUM_LANES*WIDTH-1:0] out_data
`ifdef DEMUX8_STATS_EN
  ,
  output logic [NUM_LANES*STAT_W-1:0] stat_count
`endif
);

  logic [NUM_LANES-1:0] w_accept;
  logic [NUM_LANES-1:0] w_empty;
  logic                 w_in_ready;

  // Ready only looks at the addressed lane, so a stalled lane never blocks
  // traffic to the others. Held low during reset so nothing is accepted.
  assign w_in_ready = !rst && (w_empty[in_sel] || out_ready[in_sel]);
  assign in_ready   = w_in_ready;

  always_comb begin
    w_accept = '0;
    if (in_valid && w_in_ready) w_accept[in_sel] = 1'b1;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    demux8_lane #(
      .WIDTH (WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .accept_i (w_accept[i]),
      .drain_i  (out_ready[i]),
      .data_i   (in_data),
      .valid_o  (out_valid[i]),
      .data_o   (out_data[i*WIDTH +: WIDTH]),
      .empty_o  (w_empty[i])
    );
  end

`ifdef DEMUX8_STATS_EN
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_stat
    logic [STAT_W-1:0] count_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        count_q <= '0;
      end else if (w_accept[i] && (count_q != {STAT_W{1'b1}})) begin
        count_q <= count_q + {{(STAT_W-1){1'b0}}, 1'b1};
      end
    end

    assign stat_count[i*STAT_W +: STAT_W] = count_q;
  end
`endif

endmodule : demux8_stream
`default_nettype wire
